// File: rtl/io_console.sv
// io_console: memory-mapped transmit-only serial console (TXDATA at BASE, STATUS at BASE+1).
// Optional macro IO_CONSOLE_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module io_console #(
    parameter logic [15:0] BASE         = 16'hF000,
    parameter int          DEPTH        = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [15:0] address,
    inout  wire  [7:0]  data,
    input  logic        read_en,
    output logic        txd
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef IO_CONSOLE_PARITY_EN
    localparam logic PARITY_CAP = 1'b1;
`else
    localparam logic PARITY_CAP = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t        state_r, state_next_s;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_next_s;
    logic          overflow_r, overflow_next_s;
    logic [PW-1:0] clk_cnt_r, clk_cnt_next_s;
    logic [2:0]    bit_cnt_r, bit_cnt_next_s;
    logic [7:0]    shift_r, shift_next_s;
    logic          txd_r, txd_next_s;
    logic          push_s, status_rd_s, data_rd_s, empty_s, full_s;
    logic          pop_s, accept_s, drop_s, busy_s, period_end_s, parity_bit_s;
    logic          rd_drive_s;
    logic [7:0]    rd_data_s, status_s;

    assign push_s       = !read_en && (address == BASE);
    assign status_rd_s  = read_en && (address == (BASE + 16'd1));
    assign data_rd_s    = read_en && (address == BASE);
    assign empty_s      = (count_r == CW'(0));
    assign full_s       = (count_r == CW'(DEPTH));
    assign busy_s       = (state_r != ST_IDLE);
    assign pop_s        = !busy_s && !empty_s;
    // A full FIFO still takes a byte when the serializer frees a slot on the same edge.
    assign drop_s       = push_s && full_s && !pop_s;
    assign accept_s     = push_s && !drop_s;
    assign status_s     = {3'b000, PARITY_CAP, overflow_r, busy_s, empty_s, full_s};
    assign period_end_s = (clk_cnt_r == PW'(CLKS_PER_BIT - 1));
    assign txd          = txd_r;
    assign data         = rd_drive_s ? rd_data_s : 8'bzzzz_zzzz;

`ifdef IO_CONSOLE_PARITY_EN
    logic parity_r;

    function automatic logic even_parity(input logic [7:0] b);
        even_parity = ^b;
    endfunction

    // Capture the parity of each byte as it leaves the FIFO.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (pop_s) begin
            parity_r <= even_parity(mem_r[rd_ptr_r]);
        end
    end
    assign parity_bit_s = parity_r;
`else
    assign parity_bit_s = 1'b1;
`endif

    // Bus read mux: status, occupancy, or released bus.
    always_comb begin
        rd_drive_s = 1'b0;
        rd_data_s  = 8'h00;
        if (status_rd_s) begin
            rd_drive_s = 1'b1;
            rd_data_s  = status_s;
        end else if (data_rd_s) begin
            rd_drive_s = 1'b1;
            rd_data_s  = 8'(count_r);
        end else begin
            rd_drive_s = 1'b0;
            rd_data_s  = 8'h00;
        end
    end

    // Next occupancy and sticky overflow (set wins over a same-cycle clear).
    always_comb begin
        count_next_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (drop_s) begin
            overflow_next_s = 1'b1;
        end else if (status_rd_s) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge ph1) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)    rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r    <= count_next_s;
            overflow_r <= overflow_next_s;
        end
    end

    // Serializer next-state: each state holds for one bit period.
    always_comb begin
        state_next_s   = state_r;
        clk_cnt_next_s = clk_cnt_r + PW'(1);
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_next_s = {PW{1'b0}};
                if (!empty_s) begin
                    state_next_s = ST_START;
                    shift_next_s = mem_r[rd_ptr_r];
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (period_end_s) begin
                    state_next_s   = ST_DATA;
                    clk_cnt_next_s = {PW{1'b0}};
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (period_end_s) begin
                    clk_cnt_next_s = {PW{1'b0}};
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
`ifdef IO_CONSOLE_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (period_end_s) begin
                    state_next_s   = ST_STOP;
                    clk_cnt_next_s = {PW{1'b0}};
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (period_end_s) begin
                    state_next_s   = ST_IDLE;
                    clk_cnt_next_s = {PW{1'b0}};
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clk_cnt_next_s = {PW{1'b0}};
            end
        endcase
    end

    // txd is registered, so it is derived from the state being entered.
    always_comb begin
        txd_next_s = 1'b1;
        case (state_next_s)
            ST_IDLE:   txd_next_s = 1'b1;
            ST_START:  txd_next_s = 1'b0;
            ST_DATA:   txd_next_s = shift_next_s[0];
            ST_PARITY: txd_next_s = parity_bit_s;
            ST_STOP:   txd_next_s = 1'b1;
            default:   txd_next_s = 1'b1;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= {PW{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            clk_cnt_r <= clk_cnt_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
            txd_r     <= txd_next_s;
        end
    end
endmodule
